// File: rtl/mips_mem_pkg.sv
// Shared definitions for the byte-serial data-memory initiator: size encodings,
// FSM state type and the request-size to byte-count mapping.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    RESP = 2'b10
  } state_t;

  // Encoding 2'b11 is treated as a word access.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word to full width,
// selected by access size and the unsigned flag.
module load_extend
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [4*DATA_WIDTH-1:0] word,
  input  logic [1:0]              size,
  input  logic                    is_unsigned,
  output logic [4*DATA_WIDTH-1:0] result
);

  logic byte_fill;
  logic half_fill;

  assign byte_fill = ~is_unsigned & word[DATA_WIDTH-1];
  assign half_fill = ~is_unsigned & word[2*DATA_WIDTH-1];

  always_comb begin
    result = word;
    case (size)
      SIZE_BYTE: result = {{(3*DATA_WIDTH){byte_fill}}, word[DATA_WIDTH-1:0]};
      SIZE_HALF: result = {{(2*DATA_WIDTH){half_fill}}, word[2*DATA_WIDTH-1:0]};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/mem_byte_initiator.sv
// Load/store initiator that splits each request into 1, 2 or 4 sequential
// byte accesses (little-endian) on a byte-wide RAM port with combinational read.
module mem_byte_initiator
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [4*DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [4*DATA_WIDTH-1:0] rsp_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int WORD_WIDTH = 4 * DATA_WIDTH;

  state_t                  state;
  state_t                  state_next;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              size_q;
  logic                    unsigned_q;
  logic [WORD_WIDTH-1:0]   wdata_q;
  logic [WORD_WIDTH-1:0]   assembly;
  logic [WORD_WIDTH-1:0]   extended;
  logic [1:0]              idx;
  logic                    accept;
  logic                    last_byte;
  logic                    xfer_active;

  assign last_byte = ({1'b0, idx} == (byte_count(size_q) - 3'd1));

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (last_byte) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with reset keeps an aborted store from writing the byte of the reset cycle.
  assign xfer_active = (state == XFER) && !reset;
  assign mem_en      = xfer_active;
  assign mem_we      = xfer_active & we_q;
  assign mem_addr    = xfer_active ? (addr_q + ADDR_WIDTH'(idx)) : '0;
  assign mem_wdata   = xfer_active ? wdata_q[idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .word       (assembly),
    .size       (size_q),
    .is_unsigned(unsigned_q),
    .result     (extended)
  );

  assign rsp_rdata = ((state == RESP) && !we_q) ? extended : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      assembly   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q       <= req_we;
        addr_q     <= req_addr;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
        idx        <= 2'd0;
        assembly   <= '0;
      end else if (state == XFER) begin
        if (!we_q) assembly[idx*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Directed self-checking bench for mem_byte_initiator with a 256-byte RAM model
// (address bits [7:0]) and a log of every byte access.
module tb_mem_byte_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [7:0]  ram [256];
  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [7:0]  log_data[$];
  int          accept_cycles[$];

  always #5 clk = ~clk;

  mem_byte_initiator #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = ram[mem_addr[7:0]];

  // RAM model with synchronous write, plus access and accept logging.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (req_valid && req_ready) accept_cycles.push_back(cycle);
    if (mem_en) begin
      log_addr.push_back(mem_addr);
      log_we.push_back(mem_we);
      log_data.push_back(mem_wdata);
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  // Called at a negedge while idle; returns at the negedge of the first XFER cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // cyc = cycle index after accept in which rsp_valid is first seen (bounded).
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int cyc);
    issue(we, addr, size, uns, wdata);
    wait_rsp(cyc);
    rdata = rsp_rdata;
    finish_rsp();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready got=%0b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rsp_rdata got=%08h want=00000000", rsp_rdata); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_en got=%0b want=0", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we got=%0b want=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%08h want=00000000", mem_addr); end
    total++; if (mem_wdata !== 8'h0) begin bad++; $display("[TB] FAIL reset_mem_wdata got=%02h want=00", mem_wdata); end
  endtask

  task automatic test_word_store();
    logic [31:0] rd;
    int          cyc;
    logic [7:0]  exp_bytes [4];
    exp_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_log();
    do_op(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, cyc);
    total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL word_store_latency got=%0d want=5", cyc); end
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL word_store_rdata got=%08h want=00000000", rd); end
    total++; if (log_addr.size() !== 4) begin bad++; $display("[TB] FAIL word_store_count got=%0d want=4", log_addr.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      total++; if (log_addr[i] !== 32'h10 + i) begin bad++; $display("[TB] FAIL word_store_addr%0d got=%08h want=%08h", i, log_addr[i], 32'h10 + i); end
      total++; if (log_we[i] !== 1'b1) begin bad++; $display("[TB] FAIL word_store_we%0d got=%0b want=1", i, log_we[i]); end
      total++; if (log_data[i] !== exp_bytes[i]) begin bad++; $display("[TB] FAIL word_store_data%0d got=%02h want=%02h", i, log_data[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_word_load();
    logic [31:0] rd;
    int          cyc;
    clear_log();
    do_op(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, cyc);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL word_load_rdata got=%08h want=DEADBEEF", rd); end
    total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL word_load_latency got=%0d want=5", cyc); end
    total++; if (log_addr.size() !== 4) begin bad++; $display("[TB] FAIL word_load_count got=%0d want=4", log_addr.size()); end
    for (int i = 0; i < log_we.size(); i++) begin
      total++; if (log_we[i] !== 1'b0) begin bad++; $display("[TB] FAIL word_load_we%0d got=%0b want=0", i, log_we[i]); end
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] rd;
    int          cyc;
    clear_log();
    do_op(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, cyc);
    total++; if (rd !== 32'hFFFFFFDE) begin bad++; $display("[TB] FAIL lb_signed got=%08h want=FFFFFFDE", rd); end
    total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL lb_latency got=%0d want=2", cyc); end
    total++; if (log_addr.size() !== 1) begin bad++; $display("[TB] FAIL lb_count got=%0d want=1", log_addr.size()); end
    if (log_addr.size() > 0) begin
      total++; if (log_addr[0] !== 32'h13) begin bad++; $display("[TB] FAIL lb_addr got=%08h want=00000013", log_addr[0]); end
    end
    do_op(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, cyc);
    total++; if (rd !== 32'h000000DE) begin bad++; $display("[TB] FAIL lbu got=%08h want=000000DE", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd;
    int          cyc;
    do_op(1'b1, 32'h20, 2'b00, 1'b0, 32'h55, rd, cyc);
    do_op(1'b1, 32'h23, 2'b00, 1'b0, 32'h66, rd, cyc);
    clear_log();
    do_op(1'b1, 32'h21, 2'b01, 1'b0, 32'h1234ABCD, rd, cyc);
    total++; if (cyc !== 3) begin bad++; $display("[TB] FAIL sh_latency got=%0d want=3", cyc); end
    total++; if (log_addr.size() !== 2) begin bad++; $display("[TB] FAIL sh_count got=%0d want=2", log_addr.size()); end
    total++; if (ram[8'h20] !== 8'h55) begin bad++; $display("[TB] FAIL sh_ram20 got=%02h want=55", ram[8'h20]); end
    total++; if (ram[8'h21] !== 8'hCD) begin bad++; $display("[TB] FAIL sh_ram21 got=%02h want=CD", ram[8'h21]); end
    total++; if (ram[8'h22] !== 8'hAB) begin bad++; $display("[TB] FAIL sh_ram22 got=%02h want=AB", ram[8'h22]); end
    total++; if (ram[8'h23] !== 8'h66) begin bad++; $display("[TB] FAIL sh_ram23 got=%02h want=66", ram[8'h23]); end
    do_op(1'b0, 32'h21, 2'b01, 1'b0, 32'h0, rd, cyc);
    total++; if (rd !== 32'hFFFFABCD) begin bad++; $display("[TB] FAIL lh_signed got=%08h want=FFFFABCD", rd); end
    do_op(1'b0, 32'h21, 2'b01, 1'b1, 32'h0, rd, cyc);
    total++; if (rd !== 32'h0000ABCD) begin bad++; $display("[TB] FAIL lhu got=%08h want=0000ABCD", rd); end
    do_op(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, rd, cyc);
    total++; if (rd !== 32'h66ABCD55) begin bad++; $display("[TB] FAIL size11_load got=%08h want=66ABCD55", rd); end
    total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL size11_latency got=%0d want=5", cyc); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int          cyc;
    logic [31:0] exp_addr [4];
    exp_addr = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    do_op(1'b1, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h11223344, rd, cyc);
    clear_log();
    do_op(1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0, rd, cyc);
    total++; if (rd !== 32'h11223344) begin bad++; $display("[TB] FAIL wrap_rdata got=%08h want=11223344", rd); end
    total++; if (log_addr.size() !== 4) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=4", log_addr.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      total++; if (log_addr[i] !== exp_addr[i]) begin bad++; $display("[TB] FAIL wrap_addr%0d got=%08h want=%08h", i, log_addr[i], exp_addr[i]); end
    end
  endtask

  task automatic test_hold_and_ignore();
    int cyc;
    clear_log();
    accept_cycles.delete();
    issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_size  = 2'b00;
    req_wdata = 32'h77;
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready_xfer got=%0b want=0", req_ready); end
    wait_rsp(cyc);
    total++; if (cyc !== 5) begin bad++; $display("[TB] FAIL hold_latency got=%0d want=5", cyc); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid%0d got=%0b want=1", i, rsp_valid); end
      total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL hold_rdata%0d got=%08h want=DEADBEEF", i, rsp_rdata); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready%0d got=%0b want=0", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    finish_rsp();
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_idle_ready got=%0b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_idle_valid got=%0b want=0", rsp_valid); end
    total++; if (log_addr.size() !== 4) begin bad++; $display("[TB] FAIL hold_access_count got=%0d want=4", log_addr.size()); end
    total++; if (accept_cycles.size() !== 1) begin bad++; $display("[TB] FAIL hold_accept_count got=%0d want=1", accept_cycles.size()); end
  endtask

  task automatic test_back_to_back();
    accept_cycles.delete();
    rsp_ready    = 1'b1;
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_addr     = 32'h13;
    req_size     = 2'b00;
    req_unsigned = 1'b1;
    repeat (9) @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    total++; if (accept_cycles.size() !== 3) begin bad++; $display("[TB] FAIL b2b_accepts got=%0d want=3", accept_cycles.size()); end
    for (int i = 1; i < accept_cycles.size(); i++) begin
      total++; if (accept_cycles[i] - accept_cycles[i-1] !== 3) begin bad++; $display("[TB] FAIL b2b_spacing%0d got=%0d want=3", i, accept_cycles[i] - accept_cycles[i-1]); end
    end
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle_ready got=%0b want=1", req_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int          cyc;
    do_op(1'b1, 32'h30, 2'b10, 1'b0, 32'h0, rd, cyc);
    clear_log();
    issue(1'b1, 32'h30, 2'b10, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_ready got=%0b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_valid got=%0b want=0", rsp_valid); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL rmid_mem_en got=%0b want=0", mem_en); end
    total++; if (ram[8'h30] !== 8'h0D) begin bad++; $display("[TB] FAIL rmid_ram30 got=%02h want=0D", ram[8'h30]); end
    total++; if (ram[8'h31] !== 8'h00) begin bad++; $display("[TB] FAIL rmid_ram31 got=%02h want=00", ram[8'h31]); end
    total++; if (ram[8'h32] !== 8'h00) begin bad++; $display("[TB] FAIL rmid_ram32 got=%02h want=00", ram[8'h32]); end
    total++; if (ram[8'h33] !== 8'h00) begin bad++; $display("[TB] FAIL rmid_ram33 got=%02h want=00", ram[8'h33]); end
    total++; if (log_addr.size() !== 1) begin bad++; $display("[TB] FAIL rmid_access_count got=%0d want=1", log_addr.size()); end
    repeat (3) @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_no_rsp got=%0b want=0", rsp_valid); end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    @(negedge clk);
    $display("[TB] starting directed tests");
    test_reset();
    test_word_store();
    test_word_load();
    test_byte_loads();
    test_half();
    test_wrap();
    test_hold_and_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_byte_initiator.md
# mem_byte_initiator

Initiator side of the processor's byte-addressed data-memory interface. It accepts one load/store request at a time from the datapath over a valid/ready handshake. Each request is executed as 1, 2 or 4 sequential single-byte accesses in little-endian order (lowest address = LSB). Load results are returned sign- or zero-extended to 32 bits. The block sits between the MEM stage and a byte-wide RAM port with a synchronous write and a combinational (same-cycle) read.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 8, memory lane width; word = 4*DATA_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  start byte address
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- req_wdata  in  4*DATA_WIDTH  store data; low bytes used for byte/half
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  4*DATA_WIDTH  extended load data; 0 for stores
- mem_en  out  1  byte access active this cycle
- mem_we  out  1  byte write strobe
- mem_addr  out  ADDR_WIDTH  byte address
- mem_wdata  out  DATA_WIDTH  byte to write
- mem_rdata  in  DATA_WIDTH  combinational read data for mem_addr

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/size/unsigned/wdata, clear byte index to 0, set N = 1/2/4 from size (11 -> 4), go to XFER.
- XFER: mem_en=1, mem_we=latched we, mem_addr = addr + idx (mod 2^ADDR_WIDTH; wrap from 0xFFFFFFFF to 0x00000000 is legal), mem_wdata = wdata byte idx.
  - Loads capture mem_rdata into byte idx of the assembly register at the clock edge.
  - idx increments each cycle; after idx = N-1 go to RESP.
- RESP: rsp_valid=1; rsp_rdata held stable until rsp_ready.
  - rsp_rdata for loads: byte -> bit 7 replicated into [31:8] (signed) or zeros (unsigned); half -> bit 15 replicated into [31:16] or zeros; word unchanged. Stores: 0.
  - On rsp_ready go to IDLE.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside XFER.
- No misalignment checking; any address is legal for every size.

## Timing
- Reset (any state): next state IDLE, idx=0, assembly register=0. After reset: req_ready=1, rsp_valid=0, rsp_rdata=0, all mem_* = 0.
- Reset mid-XFER aborts the access. Bytes already written stay written; no response is produced.
- Accept at edge 0 -> XFER cycles 1..N -> rsp_valid first high in cycle N+1. Minimum request-to-request spacing is N+2 cycles with rsp_ready tied high.
- req_ready is 0 in XFER and RESP; req_valid there is ignored (no queueing).
- rsp_ready=1 in RESP returns to IDLE at the next edge. A new request can be accepted in the following cycle, never in the same cycle as the response handshake.
- rsp_ready outside RESP has no effect.

## Structure
- Shared package mips_mem_pkg:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - FSM state type
  - byte-count function size -> N
- Sub-module load_extend: combinational sign/zero extension from (assembled word, size, unsigned) to 32 bits. Also reused by other load paths.
- Top: FSM, byte index counter, request latches, assembly register.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> 4 write cycles with bytes EF,BE,AD,DE at 0x10..0x13; load returns 0xDEADBEEF, rsp_valid in cycle 5 after accept.
- Byte loads at 0x13 (contains 0xDE): signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; 1 mem cycle each.
- Half store 0x1234ABCD at 0x21 -> only 0x21=CD, 0x22=AB written; signed half load -> 0xFFFFABCD, unsigned -> 0x0000ABCD.
- Word load at 0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rsp_ready held low 3 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; a req_valid pulse during XFER/RESP is not accepted.
- reset asserted in 2nd XFER cycle of a word store -> only byte 0 written; next cycle IDLE, req_ready=1, rsp_valid=0, mem_en=0.
